// File: rtl/vector_accumulator.sv
// vector_accumulator: integrates ACC_LEN consecutive fixed-length vectors
// element-by-element in an inferred simple dual-port RAM and streams out
// each completed integration with valid/sync_out markers.
//
// Optional feature macro: VECTOR_ACCUMULATOR_SATURATE_EN
//   defined   -> sums clamp to the signed OUT_WIDTH range on overflow
//   undefined -> sums wrap modulo 2^OUT_WIDTH
// In both builds ovf is a sticky flag cleared only by rst.
//
// Pipeline (per enabled clock):
//   front end : resolve addr/vec_cnt (sync forces both to 0), issue the
//               RAM read for this element, capture sample and flags in s1.
//   back end  : add s1 sample to the RAM read-back (or to 0 on the first
//               vector), write the sum back, drive the output registers.
// A sample accepted on one enabled edge reaches dout on the next one.
module vector_accumulator #(
  parameter int VECLEN_BITS  = 10,
  parameter int IN_WIDTH     = 18,
  parameter int OUT_WIDTH    = 32,
  parameter int ACC_LEN_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    sync,
  input  logic [IN_WIDTH-1:0]     din,
  input  logic [ACC_LEN_BITS-1:0] acc_len,
  output logic [OUT_WIDTH-1:0]    dout,
  output logic                    valid,
  output logic                    sync_out,
  output logic                    ovf
);

  localparam int N = 1 << VECLEN_BITS;
  localparam logic [VECLEN_BITS-1:0]  LAST_ADDR = '1;
  localparam logic [VECLEN_BITS-1:0]  ADDR_ONE  = VECLEN_BITS'(1);
  localparam logic [ACC_LEN_BITS-1:0] LEN_ONE   = ACC_LEN_BITS'(1);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // control state
  state_t                  state_q, state_d;
  logic [VECLEN_BITS-1:0]  addr_q, addr_d;
  logic [ACC_LEN_BITS-1:0] vec_cnt_q, vec_cnt_d;
  logic [ACC_LEN_BITS-1:0] len_q, len_d;

  // stage-1 pipeline (sample plus the decisions made for it)
  logic                    s1_act_q, s1_act_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;
  logic                    s1_sof_q, s1_sof_d;
  logic [VECLEN_BITS-1:0]  s1_addr_q, s1_addr_d;
  logic [IN_WIDTH-1:0]     s1_din_q, s1_din_d;

  // outputs
  logic [OUT_WIDTH-1:0]    dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    sync_out_q, sync_out_d;
  logic                    ovf_q, ovf_d;

  // front-end helpers
  logic                    accept;
  logic [VECLEN_BITS-1:0]  addr_cur;
  logic [ACC_LEN_BITS-1:0] vcnt_cur;
  logic [ACC_LEN_BITS-1:0] len_in;
  logic [ACC_LEN_BITS-1:0] len_cur;
  logic                    boundary;
  logic                    is_last;
  logic [VECLEN_BITS-1:0]  rd_addr;

  // back-end datapath
  logic [OUT_WIDTH-1:0]        ram [0:N-1];
  logic [OUT_WIDTH-1:0]        rd_data_q;
  logic signed [OUT_WIDTH-1:0] ext_din;
  logic signed [OUT_WIDTH-1:0] addend;
  logic signed [OUT_WIDTH-1:0] raw_sum;
  logic signed [OUT_WIDTH-1:0] sum;
  logic                        ovf_det;
  logic                        wr_en;

  // Front end: element position, integration bookkeeping and RAM read address.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    vec_cnt_d  = vec_cnt_q;
    len_d      = len_q;
    s1_act_d   = 1'b0;
    s1_first_d = 1'b0;
    s1_last_d  = 1'b0;
    s1_sof_d   = 1'b0;
    s1_addr_d  = addr_q;
    s1_din_d   = din;

    // Sync restarts the vector and the integration; at the natural
    // boundary addr_q/vec_cnt_q are already 0, so it changes nothing there.
    accept   = (state_q == ACC) || sync;
    addr_cur = sync ? '0 : addr_q;
    vcnt_cur = sync ? '0 : vec_cnt_q;
    boundary = (addr_cur == '0) && (vcnt_cur == '0);
    len_in   = (acc_len == '0) ? LEN_ONE : acc_len;
    // The length in force for this integration is latched at its first sample.
    len_cur  = boundary ? len_in : len_q;
    is_last  = (vcnt_cur == (len_cur - LEN_ONE));
    rd_addr  = addr_cur;

    if (accept) begin
      state_d    = ACC;
      addr_d     = addr_cur + ADDR_ONE;
      if (addr_cur == LAST_ADDR) begin
        vec_cnt_d = is_last ? '0 : (vcnt_cur + LEN_ONE);
      end else begin
        vec_cnt_d = vcnt_cur;
      end
      if (boundary) begin
        len_d = len_in;
      end
      s1_act_d   = 1'b1;
      s1_first_d = (vcnt_cur == '0);
      s1_last_d  = is_last;
      s1_sof_d   = is_last && (addr_cur == '0);
      s1_addr_d  = addr_cur;
    end
  end

  // Back end: accumulate, detect overflow, optionally clamp, drive outputs.
  always_comb begin
    ext_din = OUT_WIDTH'($signed(s1_din_q));
    // The first vector of an integration discards stale RAM contents.
    addend  = s1_first_q ? '0 : $signed(rd_data_q);
    raw_sum = addend + ext_din;
    ovf_det = (addend[OUT_WIDTH-1] == ext_din[OUT_WIDTH-1]) &&
              (raw_sum[OUT_WIDTH-1] != addend[OUT_WIDTH-1]);
`ifdef VECTOR_ACCUMULATOR_SATURATE_EN
    if (ovf_det) begin
      sum = addend[OUT_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin
      sum = raw_sum;
    end
`else
    sum = raw_sum;
`endif

    dout_d     = dout_q;
    valid_d    = 1'b0;
    sync_out_d = 1'b0;
    ovf_d      = ovf_q;
    wr_en      = s1_act_q;
    if (s1_act_q) begin
      valid_d    = s1_last_q;
      sync_out_d = s1_sof_q;
      if (s1_last_q) begin
        dout_d = sum;
      end
      if (ovf_det) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Control and pipeline registers; everything holds while ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      vec_cnt_q  <= '0;
      len_q      <= LEN_ONE;
      s1_act_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_din_q   <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      sync_out_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vec_cnt_q  <= vec_cnt_d;
      len_q      <= len_d;
      s1_act_q   <= s1_act_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_sof_q   <= s1_sof_d;
      s1_addr_q  <= s1_addr_d;
      s1_din_q   <= s1_din_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      sync_out_q <= sync_out_d;
      ovf_q      <= ovf_d;
    end
  end

  // Accumulator RAM: write the previous element while reading the current
  // one, so read and write addresses always differ. Contents are not reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (wr_en) begin
        ram[s1_addr_q] <= sum;
      end
      rd_data_q <= ram[rd_addr];
    end
  end

  assign dout     = dout_q;
  assign valid    = valid_q;
  assign sync_out = sync_out_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_vector_accumulator.sv
// Directed testbench for vector_accumulator with N=4, IN_WIDTH=8, OUT_WIDTH=10.
// Every driven cycle is logged; a sample driven in call i shows on the
// outputs logged at call i+1.
module tb_vector_accumulator;

  localparam int VB = 2;
  localparam int IW = 8;
  localparam int OW = 10;
  localparam int AB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          sync;
  logic [IW-1:0] din;
  logic [AB-1:0] acc_len;
  logic [OW-1:0] dout;
  logic          valid;
  logic          sync_out;
  logic          ovf;

  int n = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [OW-1:0] log_dout  [0:1023];
  logic          log_valid [0:1023];
  logic          log_sync  [0:1023];
  logic          log_ovf   [0:1023];

  vector_accumulator #(
    .VECLEN_BITS (VB),
    .IN_WIDTH    (IW),
    .OUT_WIDTH   (OW),
    .ACC_LEN_BITS(AB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .sync    (sync),
    .din     (din),
    .acc_len (acc_len),
    .dout    (dout),
    .valid   (valid),
    .sync_out(sync_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // One cycle: apply inputs, take one clock edge, log outputs 1 ns later.
  task automatic drive(input logic s, input int d, input logic c);
    sync = s;
    din  = IW'(d);
    ce   = c;
    @(posedge clk);
    #1;
    if (n < 1024) begin
      log_dout[n]  = dout;
      log_valid[n] = valid;
      log_sync[n]  = sync_out;
      log_ovf[n]   = ovf;
      $display("cyc %0d ce=%0b sync=%0b din=%0d -> valid=%0b sync_out=%0b dout=%0d ovf=%0b",
               n, c, s, $signed(IW'(d)), valid, sync_out, $signed(dout), ovf);
    end
    n++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ce   = 1'b0;
    sync = 1'b0;
    din  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW+2:0] got;
    int vcount;
    do_reset();
    got = {valid, sync_out, ovf, dout};
    total_cnt++;
    if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
    else pass_cnt++;
    // No sync yet: the block must ignore input entirely.
    acc_len = AB'(1);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 33 + i, 1'b1);
      vcount += int'(log_valid[n-1]) + int'(log_sync[n-1]) + ((log_dout[n-1] != '0) ? 1 : 0);
    end
    total_cnt++;
    if (vcount !== 0) $display("FAIL idle_ignores_input: got %0d active cycles expected 0", vcount);
    else pass_cnt++;
  endtask

  task automatic test_acc3();
    int base, vcount;
    logic [OW+1:0] got, exp;
    do_reset();
    acc_len = AB'(3);
    base = n;
    for (int v = 0; v < 3; v++)
      for (int e = 0; e < 4; e++)
        drive((v == 0) && (e == 0), e + 1, 1'b1);
    for (int e = 0; e < 5; e++) drive(1'b0, 0, 1'b1);
    for (int e = 0; e < 4; e++) begin
      got = {log_valid[base+9+e], log_sync[base+9+e], log_dout[base+9+e]};
      exp = {1'b1, (e == 0), OW'(3 * (e + 1))};
      total_cnt++;
      if (got !== exp) $display("FAIL acc3_dump[%0d]: got %h expected %h", e, got, exp);
      else pass_cnt++;
    end
    vcount = 0;
    for (int i = base; i <= base + 8; i++) vcount += int'(log_valid[i]);
    total_cnt++;
    if (vcount !== 0) $display("FAIL acc3_no_early_valid: got %0d expected 0", vcount);
    else pass_cnt++;
    vcount = 0;
    for (int i = base + 13; i <= base + 16; i++) vcount += int'(log_valid[i]);
    total_cnt++;
    if (vcount !== 0) $display("FAIL acc3_next_first_vector_silent: got %0d expected 0", vcount);
    else pass_cnt++;
  endtask

  task automatic test_acc1();
    int base;
    int vals [4];
    logic [OW+1:0] got, exp;
    vals[0] = -5; vals[1] = 0; vals[2] = 7; vals[3] = 127;
    do_reset();
    acc_len = AB'(1);
    base = n;
    for (int v = 0; v < 2; v++)
      for (int e = 0; e < 4; e++)
        drive((v == 0) && (e == 0), vals[e], 1'b1);
    // acc_len=0 behaves as 1; takes effect at this boundary.
    acc_len = AB'(0);
    for (int e = 0; e < 4; e++) drive(1'b0, e + 1, 1'b1);
    drive(1'b0, 0, 1'b1);
    for (int v = 0; v < 3; v++)
      for (int e = 0; e < 4; e++) begin
        got = {log_valid[base+4*v+e+1], log_sync[base+4*v+e+1], log_dout[base+4*v+e+1]};
        exp = {1'b1, (e == 0), (v < 2) ? OW'(vals[e]) : OW'(e + 1)};
        total_cnt++;
        if (got !== exp) $display("FAIL acc1_dump[v%0d e%0d]: got %h expected %h", v, e, got, exp);
        else pass_cnt++;
      end
  endtask

  task automatic test_resync();
    int base, r, vcount;
    logic [OW+1:0] got, exp;
    do_reset();
    acc_len = AB'(4);
    base = n;
    for (int e = 0; e < 4; e++) drive(e == 0, 10, 1'b1);
    drive(1'b0, 10, 1'b1);
    drive(1'b0, 10, 1'b1);
    r = n;
    for (int v = 0; v < 4; v++)
      for (int e = 0; e < 4; e++)
        drive((v == 0) && (e == 0), 1, 1'b1);
    drive(1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b1);
    vcount = 0;
    for (int i = base; i <= r + 12; i++) vcount += int'(log_valid[i]);
    total_cnt++;
    if (vcount !== 0) $display("FAIL resync_dropped_silent: got %0d expected 0", vcount);
    else pass_cnt++;
    for (int e = 0; e < 4; e++) begin
      got = {log_valid[r+13+e], log_sync[r+13+e], log_dout[r+13+e]};
      exp = {1'b1, (e == 0), OW'(4)};
      total_cnt++;
      if (got !== exp) $display("FAIL resync_dump[%0d]: got %h expected %h", e, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    int base;
    logic [OW+1:0] got, exp;
    logic [OW-1:0] exp_val;
`ifdef VECTOR_ACCUMULATOR_SATURATE_EN
    exp_val = OW'(511);
`else
    exp_val = OW'(-8);
`endif
    do_reset();
    acc_len = AB'(8);
    base = n;
    for (int v = 0; v < 8; v++)
      for (int e = 0; e < 4; e++)
        drive((v == 0) && (e == 0), 127, 1'b1);
    drive(1'b0, 0, 1'b1);
    total_cnt++;
    if (log_ovf[base+16] !== 1'b0) $display("FAIL ovf_before_overflow: got %b expected 0", log_ovf[base+16]);
    else pass_cnt++;
    total_cnt++;
    if (log_ovf[base+17] !== 1'b1) $display("FAIL ovf_on_overflow: got %b expected 1", log_ovf[base+17]);
    else pass_cnt++;
    for (int e = 0; e < 4; e++) begin
      got = {log_valid[base+29+e], log_sync[base+29+e], log_dout[base+29+e]};
      exp = {1'b1, (e == 0), exp_val};
      total_cnt++;
      if (got !== exp) $display("FAIL ovf_dump[%0d]: got %h expected %h", e, got, exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (log_ovf[base+32] !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", log_ovf[base+32]);
    else pass_cnt++;
  endtask

  task automatic test_ce_toggle();
    int b;
    logic [OW+1:0] got, exp;
    do_reset();
    acc_len = AB'(3);
    for (int v = 0; v < 2; v++)
      for (int e = 0; e < 4; e++)
        drive((v == 0) && (e == 0), e + 1, 1'b1);
    b = n;
    // Disabled cycles carry junk data and a sync that must be ignored.
    for (int e = 0; e < 4; e++) begin
      drive(1'b0, e + 1, 1'b1);
      drive(1'b1, 99, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 0, 1'b1);
      drive(1'b1, 99, 1'b0);
    end
    for (int e = 0; e < 4; e++)
      for (int h = 0; h < 2; h++) begin
        got = {log_valid[b+2*e+2+h], log_sync[b+2*e+2+h], log_dout[b+2*e+2+h]};
        exp = {1'b1, (e == 0), OW'(3 * (e + 1))};
        total_cnt++;
        if (got !== exp) $display("FAIL ce_dump[e%0d h%0d]: got %h expected %h", e, h, got, exp);
        else pass_cnt++;
      end
    total_cnt++;
    if (log_valid[b+10] !== 1'b0) $display("FAIL ce_dump_end: got valid %b expected 0", log_valid[b+10]);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int base, idle0, base2, vcount;
    logic [OW+2:0] got3;
    logic [OW+1:0] got, exp;
    do_reset();
    acc_len = AB'(2);
    base = n;
    for (int e = 0; e < 4; e++) drive(e == 0, e + 1, 1'b1);
    for (int e = 0; e < 3; e++) drive(1'b0, e + 1, 1'b1);
    total_cnt++;
    if ({log_valid[base+6], log_dout[base+6]} !== {1'b1, OW'(4)})
      $display("FAIL rst_mid_predump: got %b/%0d expected 1/4", log_valid[base+6], log_dout[base+6]);
    else pass_cnt++;
    // Asynchronous clear, checked without any clock edge in between.
    rst = 1'b1;
    #1;
    got3 = {valid, sync_out, ovf, dout};
    total_cnt++;
    if (got3 !== '0) $display("FAIL rst_async_clear: got %h expected 0", got3);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle0 = n;
    for (int i = 0; i < 6; i++) drive(1'b0, 5, 1'b1);
    base2 = n;
    for (int v = 0; v < 2; v++)
      for (int e = 0; e < 4; e++)
        drive((v == 0) && (e == 0), e + 1, 1'b1);
    for (int e = 0; e < 5; e++) drive(1'b0, 0, 1'b1);
    vcount = 0;
    for (int i = idle0; i <= base2 + 4; i++) vcount += int'(log_valid[i]);
    total_cnt++;
    if (vcount !== 0) $display("FAIL rst_no_valid_before_dump: got %0d expected 0", vcount);
    else pass_cnt++;
    for (int e = 0; e < 4; e++) begin
      got = {log_valid[base2+5+e], log_sync[base2+5+e], log_dout[base2+5+e]};
      exp = {1'b1, (e == 0), OW'(2 * (e + 1))};
      total_cnt++;
      if (got !== exp) $display("FAIL rst_resume_dump[%0d]: got %h expected %h", e, got, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    ce      = 1'b0;
    sync    = 1'b0;
    din     = '0;
    acc_len = AB'(1);
    test_reset();
    test_acc3();
    test_acc1();
    test_resync();
    test_overflow();
    test_ce_toggle();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/vector_accumulator.md
# vector_accumulator

Integrating stage that consumes a stream of fixed-length vectors, such as FFT or PFB output spectra or the output of a BRAM delay line, and sums ACC_LEN consecutive vectors element-by-element in on-chip RAM. It emits each completed integrated vector as a streaming dump with valid and sync markers. It sits downstream of the delay/FFT pipeline and upstream of the readout/packetiser.

## Interface
- VECLEN_BITS, 10: log2 of vector length; N = 2^VECLEN_BITS elements; minimum 2.
- IN_WIDTH, 18: signed input sample width.
- OUT_WIDTH, 32: signed accumulator and output width; must be at least IN_WIDTH.
- ACC_LEN_BITS, 16: width of acc_len.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; all state advances only when ce=1.
- sync  in  1  marks element 0 of a vector, coincident with that sample.
- din  in  IN_WIDTH  signed input sample.
- acc_len  in  ACC_LEN_BITS  vectors per integration; 0 is treated as 1.
- dout  out  OUT_WIDTH  signed integrated sample.
- valid  out  1  dout carries a completed integration element.
- sync_out  out  1  high with dout of element 0 of each dump.
- ovf  out  1  sticky overflow flag.

## Operation
- States:
  - IDLE: after reset, input is ignored until the first sync.
  - ACC: accumulating.
- Transition: IDLE→ACC on sync with ce=1.
- Counters:
  - addr (VECLEN_BITS bits) increments per ce cycle, wraps N-1→0, and is forced to 0 on sync.
  - vec_cnt (ACC_LEN_BITS bits) counts completed vectors within the integration.
- Per element in ACC:
  - vec_cnt==0: ram[addr] ← sign_extend(din); the previous contents are discarded.
  - otherwise: ram[addr] ← ram[addr] + sign_extend(din).
- acc_len is latched at addr==0 and vec_cnt==0. Changes take effect at the next integration boundary only.
- Last vector (vec_cnt == latched_len-1):
  - The sum is presented on dout with valid=1.
  - The RAM write is still performed, but its value is don't-care.
  - vec_cnt wraps to 0 at addr N-1, so the next integration starts with no gap.
- latched_len==1: every vector is dumped unmodified (sign-extended).
- Sync while in ACC at addr≠0 or vec_cnt≠0 (resync):
  - addr and vec_cnt go to 0.
  - The partial integration is dropped; no valid is emitted for it.
  - The current sample becomes element 0 of a new integration's first vector.
- Sync exactly at the expected boundary (addr would wrap to 0 and vec_cnt==0): no disturbance.
- Overflow:
  - Detected when the sign of the add result disagrees with the operands' common sign.
  - Sets ovf; ovf stays set until rst.
- RAM: a simple dual-port inferred block RAM. The read address is issued one cycle ahead of the write. N ≥ 4 guarantees no read/write collision on the same address.

## Timing
- Reset values: dout=0, valid=0, sync_out=0, ovf=0, state IDLE, addr=0, vec_cnt=0. RAM contents are not reset.
- Latency: the sample accepted at ce-cycle t appears on dout at ce-cycle t+2 (2 enabled clocks).
  - valid and sync_out are aligned with dout.
- Dump: N consecutive valid cycles (when ce is held high), element order 0..N-1. sync_out is high on element 0 only.
- ce=0: all registers, including the outputs, hold their values. valid is not forced low.
- rst asserted mid-dump: outputs clear immediately, asynchronously. After release the block waits in IDLE for a sync.
- Throughput: one sample per ce cycle, no back-pressure.

## Configuration
- VECTOR_ACCUMULATOR_SATURATE_EN defined:
  - On overflow, the stored sum and dout clamp to +2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
  - ovf is set.
- Undefined:
  - Sums wrap modulo 2^OUT_WIDTH.
  - ovf is still set.

## Test plan
All scenarios use VECLEN_BITS=2 (N=4), IN_WIDTH=8, OUT_WIDTH=10.
- acc_len=3, sync then din=1,2,3,4 repeated for 3 vectors, ce=1 → dout 3,6,9,12 with valid, 2 cycles after the last vector's samples; sync_out high on 3 only.
- acc_len=1, din=-5,0,7,127 → dout -5,0,7,127 each vector; valid on every cycle after the first vector plus latency.
- acc_len=4, sync re-asserted at addr 2 of vector 1 → no valid for the dropped integration; the next dump arrives 4 full vectors after the resync sync.
- acc_len=8, din=127 constant:
  - with VECTOR_ACCUMULATOR_SATURATE_EN → dout=511, ovf=1.
  - without it → dout=(8·127 mod 1024) as signed = -8, ovf=1.
- ce toggled 1,0,1,0 during a dump → dout/valid advance only on ce=1 cycles; the sequence is identical to the ce=1 run.
- rst pulsed mid-accumulation → outputs 0 immediately; no valid until a sync followed by acc_len full vectors.
